// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered read data,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_din,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_dout,
  output logic                     o_dout_valid,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_almost_full,
  output logic                     o_almost_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow,
  input  logic                     i_clr_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_wr_acc, w_rd_acc;
  // Flags derive from registered pointers only; the extra MSB tells full from empty.
  assign o_count        = r_wp - r_rp;
  assign o_empty        = r_wp == r_rp;
  assign o_full         = o_count == (AW+1)'(DEPTH);
  assign o_almost_full  = o_count >= (AW+1)'(AF_THRESH);
  assign o_almost_empty = o_count <= (AW+1)'(AE_THRESH);
  assign w_wr_acc       = i_wr_en & ~o_full;
  assign w_rd_acc       = i_rd_en & ~o_empty;
  always_ff @(posedge clk)
    if (w_wr_acc & ~reset) r_mem[r_wp[AW-1:0]] <= i_din;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp         <= '0;
      r_rp         <= '0;
      o_dout       <= '0;
      o_dout_valid <= 1'b0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + 1'b1;
      if (w_rd_acc) begin
        r_rp   <= r_rp + 1'b1;
        o_dout <= r_mem[r_rp[AW-1:0]];
      end
      o_dout_valid <= w_rd_acc;
      o_overflow   <= (o_overflow & ~i_clr_err) | (i_wr_en & o_full);
      o_underflow  <= (o_underflow & ~i_clr_err) | (i_rd_en & o_empty);
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench; stimulus pushes expected read
// data into a queue and a negedge monitor checks every dout_valid pulse.
module tb_sync_fifo_param;
  logic       clk = 0, reset = 1;
  logic       wr_en = 0, rd_en = 0, clr_err = 0;
  logic [7:0] din = 0;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  logic [7:0] q[$];
  logic       started = 0;
  int         n_tests = 0, n_fail = 0, n_valid = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .i_wr_en(wr_en), .i_din(din), .i_rd_en(rd_en),
    .o_dout(dout), .o_dout_valid(dout_valid), .o_full(full), .o_empty(empty),
    .o_almost_full(almost_full), .o_almost_empty(almost_empty), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow), .i_clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (started && dout_valid === 1'b1) begin
      n_valid++;
      if (q.size() == 0) check("unexpected_dout_valid", 32'(dout), 32'hFFFF_FFFF);
      else check("dout", 32'(dout), 32'(q.pop_front()));
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1; din = base + 8'(i);
      tick;
    end
    wr_en = 0;
  endtask

  task automatic read_n(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rd_en = 1; q.push_back(base + 8'(i));
      tick;
    end
    rd_en = 0;
  endtask

  task automatic clear_err;
    clr_err = 1; tick; clr_err = 0;
  endtask

  initial begin
    tick; tick;
    reset = 0; started = 1;
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_dv", 32'(dout_valid), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
    // Fill with 0x00..0x0F, watching the thresholds step.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; din = 8'(i);
      tick;
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_ae", 32'(almost_empty), 32'(i + 1 <= 2));
      check("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
    end
    check("fill_full", 32'(full), 1);
    din = 8'hAA; tick; wr_en = 0;
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(count), 16);
    // Drain with one extra read into empty.
    for (int i = 0; i < 17; i++) begin
      rd_en = 1;
      if (i < 16) q.push_back(8'(i));
      tick;
    end
    rd_en = 0;
    check("drain_empty", 32'(empty), 1);
    check("drain_unf", 32'(underflow), 1);
    check("drain_hold", 32'(dout), 32'h0F);
    check("drain_dv", 32'(dout_valid), 0);
    check("drain_pulses", 32'(n_valid), 16);
    clear_err;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_unf", 32'(underflow), 0);
    // Concurrent streaming across pointer wraps.
    write_n(4, 8'h10);
    for (int i = 0; i < 40; i++) begin
      wr_en = 1; rd_en = 1; din = 8'h14 + 8'(i); q.push_back(8'h10 + 8'(i));
      tick;
      check("stream_count", 32'(count), 4);
    end
    wr_en = 0; rd_en = 0;
    read_n(4, 8'h38);
    check("stream_empty", 32'(empty), 1);
    // Simultaneous access at full.
    write_n(16, 8'h40);
    wr_en = 1; rd_en = 1; din = 8'hEE; q.push_back(8'h40);
    tick;
    wr_en = 0; rd_en = 0;
    check("bfull_count", 32'(count), 15);
    check("bfull_ovf", 32'(overflow), 1);
    check("bfull_unf", 32'(underflow), 0);
    read_n(15, 8'h41);
    check("bfull_empty", 32'(empty), 1);
    clear_err;
    // Simultaneous access at empty: no fall-through.
    wr_en = 1; rd_en = 1; din = 8'h77;
    tick;
    wr_en = 0; rd_en = 0;
    check("bempty_count", 32'(count), 1);
    check("bempty_unf", 32'(underflow), 1);
    check("bempty_dv", 32'(dout_valid), 0);
    read_n(1, 8'h77);
    clear_err;
    // Error clear, then set wins over a simultaneous clear.
    write_n(16, 8'h80);
    wr_en = 1; tick; wr_en = 0;
    check("err_ovf_set", 32'(overflow), 1);
    clear_err;
    check("err_ovf_clr", 32'(overflow), 0);
    clr_err = 1; wr_en = 1; tick; clr_err = 0; wr_en = 0;
    check("err_set_wins", 32'(overflow), 1);
    // Reset mid-operation with a read requested on the reset edge.
    read_n(7, 8'h80);
    check("mid_count9", 32'(count), 9);
    rd_en = 1; reset = 1;
    tick;
    rd_en = 0; reset = 0;
    check("mr_count", 32'(count), 0);
    check("mr_empty", 32'(empty), 1);
    check("mr_dout", 32'(dout), 0);
    check("mr_dv", 32'(dout_valid), 0);
    check("mr_ovf", 32'(overflow), 0);
    check("mr_unf", 32'(underflow), 0);
    write_n(1, 8'h5A);
    read_n(1, 8'h5A);
    tick; tick;
    check("sb_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
